// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store controller
//
// Purpose : widths, memory depth, FSM state enum and the request struct
//           shared between the execute stage and lsu_ctrl.
// Contents: ADDR_W, DATA_W, DEPTH, TAG_W, lsu_state_e, lsu_req_t, addr_oob()
package lsu_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int TAG_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } lsu_req_t;

    // The 6-bit address space is larger than the implemented memory.
    function automatic logic addr_oob(input logic [ADDR_W-1:0] addr);
        return addr >= ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - request, memory and response bus of the load/store controller
//
// Purpose : bundles the execute-side request handshake, the data memory port,
//           the writeback response handshake and the status outputs.
// Modports: slave  - the controller (lsu_ctrl)
//           master - the surrounding core (execute stage, memory, writeback)
interface lsu_ctrl_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;

    logic              err_oob;
    logic [15:0]       op_cnt;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_tag,
        input  mem_rdata, rsp_ready,
        output req_ready, mem_addr, mem_wdata, mem_we, mem_re,
        output rsp_valid, rsp_data, rsp_tag, err_oob, op_cnt
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_tag,
        output mem_rdata, rsp_ready,
        input  req_ready, mem_addr, mem_wdata, mem_we, mem_re,
        input  rsp_valid, rsp_data, rsp_tag, err_oob, op_cnt
    );

endinterface

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller in front of the 32x16 data memory
//
// Purpose : accepts one load/store per request, drives registered memory
//           strobes, returns load data with its tag to writeback, flags
//           out-of-range addresses and counts completed operations.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - lsu_ctrl_if.slave (request, memory, response, status)
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e        r_state;
    logic              r_we;
    logic              r_oob;
    logic [TAG_W-1:0]  r_tag;

    lsu_req_t          w_req;
    logic              w_oob;

    assign w_req = '{we:    bus.req_we,
                     addr:  bus.req_addr,
                     wdata: bus.req_wdata,
                     tag:   bus.req_tag};
    assign w_oob = addr_oob(w_req.addr);

    assign bus.req_ready = (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_oob         <= 1'b0;
            r_tag         <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_tag   <= '0;
            bus.err_oob   <= 1'b0;
            bus.op_cnt    <= '0;
        end else begin
            // Strobes and the error flag are single-cycle pulses.
            bus.mem_we  <= 1'b0;
            bus.mem_re  <= 1'b0;
            bus.err_oob <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= w_req.we;
                        r_tag       <= w_req.tag;
                        r_oob       <= w_oob;
                        bus.err_oob <= w_oob;
                        // Strobes are set here so they are high during ISSUE;
                        // address/data only move for requests that really reach memory.
                        if (!w_oob) begin
                            bus.mem_addr <= w_req.addr;
                            bus.mem_we   <= w_req.we;
                            bus.mem_re   <= !w_req.we;
                            if (w_req.we) begin
                                bus.mem_wdata <= w_req.wdata;
                            end
                        end
                        r_state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (r_we) begin
                        // Dropped out-of-range stores are not counted.
                        if (!r_oob) begin
                            bus.op_cnt <= bus.op_cnt + 16'd1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    bus.rsp_data  <= r_oob ? '0 : bus.mem_rdata;
                    bus.rsp_tag   <= r_tag;
                    bus.rsp_valid <= 1'b1;
                    r_state       <= RESP;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.op_cnt    <= bus.op_cnt + 16'd1;
                        r_state       <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory: one-cycle read path, preloaded with mem[i] = i on reset.
    logic [15:0] mem [0:31];
    logic [15:0] rdata_q;
    assign bus.mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'(i);
            rdata_q <= 16'h0;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
            if (bus.mem_re) rdata_q <= mem[bus.mem_addr[4:0]];
            else            rdata_q <= 16'hA5A5;
        end
    end

    // Reference model: memory contents and completed-operation count.
    logic [15:0] ref_mem [0:31];
    logic [15:0] exp_cnt;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_mem[i] = 16'(i);
        exp_cnt = 16'h0;
    endtask

    // Runs one request to completion; starts and ends at a negedge in IDLE.
    task automatic do_req(input logic we, input logic [5:0] addr,
                          input logic [15:0] wdata, input logic [2:0] tag, input int delay);
        logic        oob;
        logic [15:0] exp_d;
        oob = (addr >= 6'd32);
        check("ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_tag   = tag;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 6'($urandom);
        bus.req_wdata = 16'($urandom);
        check("ready_issue", bus.req_ready, 0);
        check("err_oob", bus.err_oob, oob);
        check("mem_we", bus.mem_we, we && !oob);
        check("mem_re", bus.mem_re, !we && !oob);
        if (!oob) check("mem_addr", bus.mem_addr, addr);
        if (we && !oob) begin
            check("mem_wdata", bus.mem_wdata, wdata);
            ref_mem[addr[4:0]] = wdata;
            exp_cnt = exp_cnt + 16'd1;
        end
        @(negedge clk);
        check("we_low", bus.mem_we, 0);
        check("re_low", bus.mem_re, 0);
        check("err_low", bus.err_oob, 0);
        if (we) begin
            check("ready_after_store", bus.req_ready, 1);
            check("op_cnt_store", bus.op_cnt, exp_cnt);
        end else begin
            check("ready_wait", bus.req_ready, 0);
            check("rsp_valid_wait", bus.rsp_valid, 0);
            @(negedge clk);
            exp_d = oob ? 16'h0 : ref_mem[addr[4:0]];
            for (int k = 0; k <= delay; k++) begin
                check("rsp_valid", bus.rsp_valid, 1);
                check("rsp_data", bus.rsp_data, exp_d);
                check("rsp_tag", bus.rsp_tag, tag);
                check("ready_resp", bus.req_ready, 0);
                check("strobes_resp", {bus.mem_we, bus.mem_re}, 0);
                if (k < delay) @(negedge clk);
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            exp_cnt = exp_cnt + 16'd1;
            check("rsp_valid_drop", bus.rsp_valid, 0);
            check("ready_after_rsp", bus.req_ready, 1);
            check("op_cnt_load", bus.op_cnt, exp_cnt);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_re", bus.mem_re, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_tag", bus.rsp_tag, 0);
        check("rst_err_oob", bus.err_oob, 0);
        check("rst_op_cnt", bus.op_cnt, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();
        @(negedge clk);

        // Basic load, store then load-back, backpressure.
        do_req(1'b0, 6'd5, 16'h0, 3'd3, 0);
        do_req(1'b1, 6'd7, 16'hBEEF, 3'd0, 0);
        do_req(1'b0, 6'd7, 16'h0, 3'd6, 0);
        do_req(1'b0, 6'd9, 16'h0, 3'd2, 5);

        // Out-of-range store and load.
        do_req(1'b1, 6'd40, 16'h1234, 3'd1, 0);
        do_req(1'b0, 6'd63, 16'h0, 3'd5, 1);
        do_req(1'b0, 6'd32, 16'h0, 3'd7, 0);
        do_req(1'b0, 6'd31, 16'h0, 3'd4, 0);

        // Reset during WAIT of a load discards it.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'd2;
        bus.req_tag   = 3'd6;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_outputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", bus.rsp_valid, 0);
        end
        do_req(1'b0, 6'd1, 16'h0, 3'd3, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(32, 63))
                                            : 6'($urandom_range(0, 31));
            do_req(1'($urandom), a, 16'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
        end

        // Counter wrap: jump the counter near its limit, then back-to-back stores.
        force bus.op_cnt = 16'hFFFD;
        #1;
        release bus.op_cnt;
        exp_cnt = 16'hFFFD;
        do_req(1'b1, 6'd3, 16'h1111, 3'd0, 0);
        do_req(1'b1, 6'd4, 16'h2222, 3'd0, 0);
        check("op_cnt_ffff", bus.op_cnt, 16'hFFFF);
        do_req(1'b1, 6'd5, 16'h3333, 3'd0, 0);
        check("op_cnt_wrap", bus.op_cnt, 16'h0000);
        do_req(1'b0, 6'd4, 16'h0, 3'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store controller sitting directly upstream of the 32-word x 16-bit data memory in the 16-bit Harvard core. Accepts one load or store per request from the execute stage over a valid/ready handshake and drives the memory's address, read and write strobes with registered signals. Captures load data from the memory's one-cycle read path and returns it, with its destination register tag, to writeback over a second valid/ready handshake. Flags out-of-range addresses: the 6-bit address space exceeds the 32 implemented words.

Parameters:
ADDR_W, 6, request/memory address width
DATA_W, 16, data word width
DEPTH, 32, implemented memory words; an address >= DEPTH is out of range
TAG_W, 3, destination register tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  controller can accept; equals (state==IDLE)
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
req_tag  in  TAG_W  load destination register
mem_addr  out  ADDR_W  registered address to data memory
mem_wdata  out  DATA_W  registered store data
mem_we  out  1  one-cycle write strobe
mem_re  out  1  one-cycle read strobe
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
rsp_valid  out  1  load result available
rsp_ready  in  1  writeback accepts the result
rsp_data  out  DATA_W  load result
rsp_tag  out  TAG_W  tag of the load
err_oob  out  1  one-cycle pulse on an out-of-range request
op_cnt  out  16  completed operations: stores issued plus responses handed off

Behaviour:
- Reset: state=IDLE; mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, rsp_valid=0, rsp_data=0, rsp_tag=0, err_oob=0, op_cnt=0. Reset overrides every other event in the same cycle, including a handshake; an in-flight operation is discarded.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, wdata, we and tag, then go to ISSUE. If req_addr >= DEPTH, pulse err_oob in the next cycle.
- ISSUE, one cycle:
  - In-range store: mem_we=1, next state IDLE.
  - In-range load: mem_re=1, next state WAIT.
  - Out-of-range store: no strobe, next state IDLE.
  - Out-of-range load: no strobe, next state WAIT; the data captured in WAIT is forced to 0.
- WAIT, one cycle: capture mem_rdata (or 0 if out of range) into rsp_data and the latched tag into rsp_tag, then go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_tag stay stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE; rsp_valid falls on the next edge.
- req_ready is 0 in ISSUE, WAIT and RESP. There is no bypass: a request offered in the handoff cycle is accepted only in the following IDLE cycle.
- Latency:
  - Load: accept at cycle 0, mem_re at cycle 1, capture at cycle 2, rsp_valid at cycle 3 at the earliest. Best-case throughput is one load per 4 cycles.
  - Store: accept at cycle 0, mem_we at cycle 1, next accept at cycle 2.
- mem_we and mem_re are never high together and are each high for exactly one cycle per request.
- mem_addr and mem_wdata hold their last value outside strobe cycles.
- op_cnt increments by 1 on each in-range mem_we cycle and on each response handshake. It does not count dropped out-of-range stores. It wraps 0xFFFF -> 0x0000.

Decomposition:
- Package lsu_pkg holds: state enum {IDLE, ISSUE, WAIT, RESP}; constants ADDR_W, DATA_W, DEPTH, TAG_W; and a request struct {we, addr, wdata, tag}, shared with the execute stage.
- Single module; no sub-module needed. The response register is small enough to live inline.

Test Plan:
- After reset: load addr 5 with tag 3 -> mem_re high for one cycle at cycle 1 with mem_addr=5; rsp_valid at cycle 3 with rsp_data=0x0005 (preloaded memory), rsp_tag=3; op_cnt=1.
- Store 0xBEEF to addr 7, then load addr 7 -> mem_we pulse with mem_addr=7 and mem_wdata=0xBEEF; the load returns 0xBEEF; op_cnt=2; req_ready low only in each ISSUE/WAIT/RESP cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load of addr 9 -> rsp_valid stays 1, rsp_data=0x0009 stable, req_ready=0 throughout; release -> IDLE on the next edge.
- Out of range: store to addr 40 -> err_oob pulse, no mem_we, op_cnt unchanged. Load from addr 63 -> err_oob pulse, no mem_re, rsp_data=0.
- Assert rst during WAIT of a load -> next cycle all outputs are at reset values and no rsp_valid appears; a following load of addr 1 completes normally.
- Preload op_cnt to 0xFFFF via back-to-back stores -> the next store wraps op_cnt to 0x0000.
